// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - shared owner, arbiter state and SRAM-like size encodings
package sram_req_arbiter_pkg;

    localparam logic ARB_OWN_INST = 1'b0;
    localparam logic ARB_OWN_DATA = 1'b1;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_LOCK_I = 2'd1;
    localparam logic [1:0] ARB_LOCK_D = 2'd2;

    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

    typedef struct packed {
        logic owner;
        logic drop;
    } owner_entry_t;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// rtl/sram_req_arbiter_owner_fifo.sv - in-order owner tag FIFO with per-entry drop bit
module arb_owner_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    input  logic mark_inst,
    output logic head_owner,
    output logic head_drop,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_entry_t     entries [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [2:0]       count;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == 3'(DEPTH));
    assign empty      = (count == 3'd0);
    assign push_en    = push && !full;
    assign pop_en     = pop && !empty;
    assign head_owner = entries[rd_ptr].owner;
    assign head_drop  = entries[rd_ptr].drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mark_inst && entries[i].owner == ARB_OWN_INST) begin
                    entries[i].drop <= 1'b1;
                end
            end
            // The pushed slot is rewritten after the bulk mark so a same-cycle cancel still tags it
            if (push_en) begin
                entries[wr_ptr].owner <= push_owner;
                entries[wr_ptr].drop  <= mark_inst && (push_owner == ARB_OWN_INST);
                wr_ptr                <= ptr_next(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - inst/data SRAM-like arbiter with in-order response routing; ARB_ROUND_ROBIN_EN selects round-robin
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       idle_pick_inst;
    logic       grant_inst;
    logic       accept;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       head_owner;
    logic       head_drop;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_winner <= ARB_OWN_INST;
        end else if (accept) begin
            last_winner <= grant_inst ? ARB_OWN_INST : ARB_OWN_DATA;
        end
    end

    assign idle_pick_inst = (inst_req && data_req) ? (last_winner == ARB_OWN_DATA) : inst_req;
`else
    assign idle_pick_inst = inst_req && !data_req;
`endif

    always_comb begin
        grant_inst = 1'b0;
        case (state)
            ARB_LOCK_I: grant_inst = 1'b1;
            ARB_LOCK_D: grant_inst = 1'b0;
            default:    grant_inst = idle_pick_inst;
        endcase
    end

    assign mem_req   = !reset && (state != ARB_IDLE || inst_req || data_req) && !fifo_full;
    assign mem_wr    = grant_inst ? 1'b0           : data_wr;
    assign mem_size  = grant_inst ? SRAM_SIZE_WORD : data_size;
    assign mem_wstrb = grant_inst ? 4'h0           : data_wstrb;
    assign mem_addr  = grant_inst ? inst_addr      : data_addr;
    assign mem_wdata = grant_inst ? 32'h0          : data_wdata;

    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && grant_inst;
    assign data_addr_ok = accept && !grant_inst;

    // A cancel in the same cycle also suppresses the head response being returned now
    assign pop          = !reset && mem_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (head_owner == ARB_OWN_INST) && !(head_drop || inst_cancel);
    assign data_data_ok = pop && (head_owner == ARB_OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = ARB_IDLE;
        end else if (mem_req) begin
            state_nxt = grant_inst ? ARB_LOCK_I : ARB_LOCK_D;
        end
        if (inst_cancel && state_nxt == ARB_LOCK_I) begin
            state_nxt = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_owner (grant_inst ? ARB_OWN_INST : ARB_OWN_DATA),
        .pop        (pop),
        .mark_inst  (inst_cancel),
        .head_owner (head_owner),
        .head_drop  (head_drop),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - randomized bench for sram_req_arbiter against a queue-based reference model
module tb_sram_req_arbiter;

    localparam int MAX_OUT = 2;
    localparam int NCYC    = 3000;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outstanding transactions in acceptance order: who issued it and whether its answer is discarded
    typedef struct {
        bit is_inst;
        bit drop;
    } txn_t;
    txn_t q[$];

    int  lock_who;   // requester that has been presented but not yet accepted: 0 none, 1 inst, 2 data
    bit  last_data;  // previous acceptance went to data
    bit  i_pend, d_pend;

    task automatic model_reset();
        q.delete();
        lock_who  = 0;
        last_data = 1'b0;
        i_pend    = 1'b0;
        d_pend    = 1'b0;
    endtask

    task automatic drive_idle();
        inst_req = 1'b0; inst_addr = 32'h0; inst_cancel = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_inst_addr_ok"}, inst_addr_ok, 0);
        chk({tag, "_data_addr_ok"}, data_addr_ok, 0);
        chk({tag, "_inst_data_ok"}, inst_data_ok, 0);
        chk({tag, "_data_data_ok"}, data_data_ok, 0);
    endtask

    initial begin
        int  who;
        bit  e_req, accept, has_resp, e_iok, e_dok;
        txn_t nt;

        model_reset();
        drive_idle();
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        #2;
        check_quiet("reset");
        @(posedge clk); #1;
        drive_idle();
        reset = 1'b0;
        mem_data_ok = 1'b1;
        #3;
        check_quiet("stray_after_reset");

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk); #1;

            if (cyc == NCYC / 2) begin
                reset = 1'b1;
                inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
                #3;
                check_quiet("midreset");
                @(posedge clk); #1;
                reset = 1'b0;
                model_reset();
                drive_idle();
                mem_data_ok = 1'b1;
                #3;
                check_quiet("stray_after_midreset");
                continue;
            end

            // Requesters keep a request stable until it is accepted
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend    = 1'b1;
                inst_addr = $urandom & 32'hffff_fffc;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend     = 1'b1;
                data_wr    = 1'($urandom);
                data_size  = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            inst_req    = i_pend;
            data_req    = d_pend;
            inst_cancel = ($urandom_range(0, 15) == 0);
            mem_addr_ok = ($urandom_range(0, 1) == 0);
            mem_data_ok = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            mem_rdata   = $urandom;

            if (lock_who != 0)         who = lock_who;
            else if (i_pend && d_pend) who = (RR_EN && last_data) ? 1 : 2;
            else if (i_pend)           who = 1;
            else if (d_pend)           who = 2;
            else                       who = 0;

            e_req    = (who != 0) && (q.size() < MAX_OUT);
            accept   = e_req && mem_addr_ok;
            has_resp = mem_data_ok && (q.size() > 0);
            e_iok    = has_resp && q[0].is_inst && !q[0].drop && !inst_cancel;
            e_dok    = has_resp && !q[0].is_inst;

            #3;
            chk("mem_req", mem_req, e_req);
            if (e_req) begin
                chk("mem_addr", mem_addr, (who == 1) ? inst_addr : data_addr);
                chk("mem_wr", mem_wr, (who == 1) ? 1'b0 : data_wr);
                chk("mem_size", mem_size, (who == 1) ? 2'd2 : data_size);
                chk("mem_wstrb", mem_wstrb, (who == 1) ? 4'h0 : data_wstrb);
                if (who == 2) chk("mem_wdata", mem_wdata, data_wdata);
            end
            chk("inst_addr_ok", inst_addr_ok, accept && who == 1);
            chk("data_addr_ok", data_addr_ok, accept && who == 2);
            chk("inst_data_ok", inst_data_ok, e_iok);
            chk("data_data_ok", data_data_ok, e_dok);
            if (e_iok) chk("inst_rdata", inst_rdata, mem_rdata);
            if (e_dok) chk("data_rdata", data_rdata, mem_rdata);

            if (has_resp) void'(q.pop_front());
            if (inst_cancel) begin
                foreach (q[k]) if (q[k].is_inst) q[k].drop = 1'b1;
            end
            if (accept) begin
                nt.is_inst = (who == 1);
                nt.drop    = inst_cancel && (who == 1);
                q.push_back(nt);
                last_data = (who == 2);
                if (who == 1) i_pend = 1'b0;
                else          d_pend = 1'b0;
                lock_who = 0;
            end else if (e_req) begin
                lock_who = who;
            end
            if (inst_cancel) begin
                if (lock_who == 1) lock_who = 0;
                i_pend = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
